// File: rtl/max_exp_tree_pipe.sv
// max_exp_tree_pipe: pipelined masked max-exponent tree with per-group running max and valid/ready handshakes
module max_exp_tree_pipe #(
    parameter int EXP_W = 6,
    parameter int NUM_IN = 9,
    parameter int BEAT_W = 4,
    localparam int L = $clog2(NUM_IN),
    localparam int IDX_W = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_IN*EXP_W-1:0] in_exp,
    input  logic [NUM_IN-1:0]       in_skip,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W-1:0]        out_max_exp,
    output logic [IDX_W-1:0]        out_idx,
    output logic [BEAT_W-1:0]       out_beat,
    output logic [BEAT_W-1:0]       out_beats,
    output logic                    out_all_skip
);
    function automatic int cnt(int k);
        return (NUM_IN + (1 << k) - 1) >> k;
    endfunction

    logic adv;
    assign adv = !out_valid | out_ready;
    assign in_ready = adv;

    for (genvar n = 0; n <= L; n++) begin : lvl
        localparam int C = cnt(n);
        logic [EXP_W-1:0] v [C];
        logic [IDX_W-1:0] ix [C];
        logic [C-1:0] f;
        logic sv, lst;
        if (n == 0) begin : g
            assign sv = in_valid;
            assign lst = in_last;
            for (genvar j = 0; j < C; j++) begin : c
                assign v[j] = in_skip[j] ? '0 : in_exp[j*EXP_W +: EXP_W];
                assign ix[j] = IDX_W'(j);
                assign f[j] = !in_skip[j];
            end
        end else begin : g
            localparam int P = cnt(n - 1);
            logic [EXP_W-1:0] nv [C];
            logic [IDX_W-1:0] ni [C];
            logic [C-1:0] nf;
            for (genvar j = 0; j < C; j++) begin : c
                if (2 * j + 1 < P) begin : p
                    // upper neighbour wins only when valid and strictly larger, so ties keep the lower channel
                    logic tk;
                    assign tk = lvl[n-1].f[2*j+1] & (!lvl[n-1].f[2*j] | (lvl[n-1].v[2*j+1] > lvl[n-1].v[2*j]));
                    assign nv[j] = tk ? lvl[n-1].v[2*j+1] : lvl[n-1].v[2*j];
                    assign ni[j] = tk ? lvl[n-1].ix[2*j+1] : lvl[n-1].ix[2*j];
                    assign nf[j] = lvl[n-1].f[2*j+1] | lvl[n-1].f[2*j];
                end else begin : s
                    assign nv[j] = lvl[n-1].v[2*j];
                    assign ni[j] = lvl[n-1].ix[2*j];
                    assign nf[j] = lvl[n-1].f[2*j];
                end
            end
            always_ff @(posedge clk) begin
                if (rst) begin
                    sv <= 1'b0;
                end else if (adv) begin
                    sv <= lvl[n-1].sv;
                    lst <= lvl[n-1].lst;
                    v <= nv;
                    ix <= ni;
                    f <= nf;
                end
            end
        end
    end

    logic [EXP_W-1:0] acc_v, nx_v;
    logic [IDX_W-1:0] acc_i, nx_i;
    logic [BEAT_W-1:0] acc_b, nx_b, beats, nx_cnt;
    logic acc_f, rep, bsv, blst;

    assign bsv = lvl[L].sv;
    assign blst = lvl[L].lst;
    assign rep = lvl[L].f[0] & (!acc_f | (lvl[L].v[0] > acc_v));
    assign nx_v = rep ? lvl[L].v[0] : acc_v;
    assign nx_i = rep ? lvl[L].ix[0] : acc_i;
    assign nx_b = rep ? beats : acc_b;
    assign nx_cnt = &beats ? beats : beats + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            {acc_v, acc_i, acc_b, acc_f, beats} <= '0;
            {out_valid, out_max_exp, out_idx, out_beat, out_beats, out_all_skip} <= '0;
        end else if (adv) begin
            out_valid <= bsv & blst;
            if (bsv & blst) begin
                out_max_exp <= nx_v;
                out_idx <= nx_i;
                out_beat <= nx_b;
                out_beats <= nx_cnt;
                out_all_skip <= !(acc_f | lvl[L].f[0]);
                {acc_v, acc_i, acc_b, acc_f, beats} <= '0;
            end else if (bsv) begin
                acc_v <= nx_v;
                acc_i <= nx_i;
                acc_b <= nx_b;
                acc_f <= acc_f | lvl[L].f[0];
                beats <= nx_cnt;
            end
        end
    end
endmodule

// File: tb/tb_max_exp_tree_pipe.sv
// tb_max_exp_tree_pipe: directed table-driven bench for max_exp_tree_pipe
module tb_max_exp_tree_pipe;
    localparam int EW = 6, N = 9, BW = 4, IW = 4;

    logic clk = 1'b0, rst, in_valid, in_ready, in_last, out_valid, out_ready, out_all_skip;
    logic [N*EW-1:0] in_exp;
    logic [N-1:0] in_skip;
    logic [EW-1:0] out_max_exp;
    logic [IW-1:0] out_idx;
    logic [BW-1:0] out_beat, out_beats;

    max_exp_tree_pipe #(.EXP_W(EW), .NUM_IN(N), .BEAT_W(BW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_exp(in_exp),
        .in_skip(in_skip), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_max_exp(out_max_exp), .out_idx(out_idx), .out_beat(out_beat),
        .out_beats(out_beats), .out_all_skip(out_all_skip)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N*EW-1:0] e;
        logic [N-1:0] s;
        logic [EW-1:0] m;
        logic [IW-1:0] i;
        logic a;
    } vec_t;
    typedef struct {
        logic [EW-1:0] m;
        logic [IW-1:0] i;
        logic [BW-1:0] b, n;
        logic a;
    } res_t;

    res_t q[$];
    int checks = 0, failures = 0;
    logic stall_p = 1'b0;
    logic [EW+IW+2*BW:0] prev;
    vec_t tbl[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [N*EW-1:0] mk(int a0, int a1, int a2, int a3, int a4, int a5, int a6, int a7, int a8);
        int a[N];
        logic [N*EW-1:0] r;
        a = '{a0, a1, a2, a3, a4, a5, a6, a7, a8};
        for (int k = 0; k < N; k++) r[k*EW +: EW] = EW'(a[k]);
        return r;
    endfunction

    function automatic logic [N*EW-1:0] fill(int base, int ch, int val);
        logic [N*EW-1:0] r;
        for (int k = 0; k < N; k++) r[k*EW +: EW] = EW'(k == ch ? val : base);
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) q.push_back('{out_max_exp, out_idx, out_beat, out_beats, out_all_skip});
        if (!rst && stall_p) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", 32'({out_max_exp, out_idx, out_beat, out_beats, out_all_skip}), 32'(prev));
        end
        stall_p = !rst && out_valid && !out_ready;
        prev = {out_max_exp, out_idx, out_beat, out_beats, out_all_skip};
    end

    task automatic send(input logic [N*EW-1:0] e, input logic [N-1:0] s, input logic l);
        in_exp = e;
        in_skip = s;
        in_last = l;
        in_valid = 1'b1;
        for (int t = 0; ; t++) begin
            @(negedge clk);
            if (in_ready) break;
            if (t == 50) begin
                checks++;
                failures++;
                $display("FAIL send_timeout: got in_ready=0 expected 1 within 50 cycles");
                break;
            end
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic get(input string nm, input res_t e);
        res_t r;
        for (int t = 0; t < 40 && q.size() == 0; t++) begin
            @(posedge clk);
            #1;
        end
        if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got no result expected one within 40 cycles", nm);
            return;
        end
        r = q.pop_front();
        chk({nm, "_max"}, 32'(r.m), 32'(e.m));
        chk({nm, "_idx"}, 32'(r.i), 32'(e.i));
        chk({nm, "_beat"}, 32'(r.b), 32'(e.b));
        chk({nm, "_beats"}, 32'(r.n), 32'(e.n));
        chk({nm, "_allskip"}, 32'(r.a), 32'(e.a));
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0] = '{mk(3, 17, 9, 17, 0, 5, 2, 1, 4), 9'h000, 6'd17, 4'd1, 1'b0};
        tbl[1] = '{mk(3, 17, 9, 17, 0, 5, 2, 1, 4), 9'h002, 6'd17, 4'd3, 1'b0};
        tbl[2] = '{mk(3, 17, 9, 17, 0, 5, 2, 1, 4), 9'h1FF, 6'd0, 4'd0, 1'b1};
        tbl[3] = '{mk(5, 5, 5, 5, 5, 5, 5, 5, 5), 9'h000, 6'd5, 4'd0, 1'b0};
        tbl[4] = '{mk(1, 2, 3, 4, 5, 6, 7, 8, 63), 9'h000, 6'd63, 4'd8, 1'b0};
        tbl[5] = '{mk(40, 40, 40, 40, 40, 40, 40, 40, 2), 9'h0FF, 6'd2, 4'd8, 1'b0};
        tbl[6] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0), 9'h000, 6'd0, 4'd0, 1'b0};
        tbl[7] = '{mk(0, 0, 0, 0, 0, 0, 0, 12, 12), 9'h080, 6'd12, 4'd8, 1'b0};

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        in_exp = '0;
        in_skip = '0;
        in_last = 1'b0;
        cyc(2);
        rst = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_max", 32'(out_max_exp), 32'd0);
        chk("rst_beats", 32'(out_beats), 32'd0);
        chk("rst_allskip", 32'(out_all_skip), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        in_exp = tbl[0].e;
        in_skip = '0;
        in_last = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            cyc(1);
            chk($sformatf("latency_edge%0d", i), 32'(out_valid), 32'(i == 4));
        end
        get("t1", '{6'd17, 4'd1, 4'd0, 4'd1, 1'b0});
        chk("t1_single_pulse", 32'(out_valid), 32'd0);

        foreach (tbl[k]) begin
            send(tbl[k].e, tbl[k].s, 1'b1);
            get($sformatf("vec%0d", k), '{tbl[k].m, tbl[k].i, 4'd0, 4'd1, tbl[k].a});
        end

        send(fill(1, 2, 10), '0, 1'b0);
        send(fill(3, 5, 22), '0, 1'b0);
        send(fill(4, 0, 22), '0, 1'b1);
        get("t3", '{6'd22, 4'd5, 4'd1, 4'd3, 1'b0});
        cyc(10);
        chk("t3_one_pulse", 32'(q.size()), 32'd0);

        fork
            for (int g = 0; g < 8; g++) send(fill(g, g, 10 + g), '0, 1'b1);
            begin
                for (int c = 0; c < 60; c++) begin
                    out_ready = (c % 4 == 0) || (c % 4 == 3);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        chk("t4_count", 32'(q.size()), 32'd8);
        for (int g = 0; g < 8; g++) get($sformatf("t4_g%0d", g), '{EW'(10 + g), IW'(g), 4'd0, 4'd1, 1'b0});

        send(fill(2, 1, 50), '0, 1'b0);
        send(fill(2, 6, 60), '0, 1'b0);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("t5_rst_valid", 32'(out_valid), 32'd0);
        send(fill(1, 4, 7), '0, 1'b1);
        get("t5", '{6'd7, 4'd4, 4'd0, 4'd1, 1'b0});
        cyc(10);
        chk("t5_one_result", 32'(q.size()), 32'd0);

        for (int b = 0; b < 20; b++) send(b == 17 ? fill(1, 3, 30) : fill(1, 0, 1), '0, b == 19);
        get("t6", '{6'd30, 4'd3, 4'd15, 4'd15, 1'b0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
